alu_multiciclo: RTL
===================

// Module: alu_multiciclo
// PURPOSE
//  Parametrised multi-cycle ALU for the MIPS datapath; successor of the 2-bit-op combinational alu.
//  Adds unsigned iterative MUL (shift-add) and DIV (restoring), plus registered flags.
//  Uses a Start/Busy/Done handshake so the control unit can stall while a long op runs.
//  Results and flags are registered and held stable until the next accepted Start.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4)
//  CNT_W  $clog2(WIDTH)+1  iteration counter width (derived, localparam)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  Start      in   1      request; sampled only when Busy=0
//  OP         in   3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 DIV, 11x reserved
//  EntradaA   in   WIDTH  operand A (dividend for DIV)
//  EntradaB   in   WIDTH  operand B (divisor for DIV)
//  Saida      out  WIDTH  result / MUL low word / DIV quotient
//  SaidaHi    out  WIDTH  MUL high word / DIV remainder / 0 for other ops
//  Zero       out  1      Saida == 0
//  Overflow   out  1      signed overflow on ADD/SUB; 0 otherwise
//  DivZero    out  1      DIV with EntradaB == 0
//  Busy       out  1      op in progress; Start ignored
//  Done       out  1      one-cycle pulse: Saida/SaidaHi/flags valid from this cycle
// BEHAVIOUR
//  Reset: all outputs 0, FSM -> IDLE, counter 0; reset mid-op aborts, no Done issued.
//  FSM IDLE: Start=1 latches OP, EntradaA, EntradaB; ADD/SUB/AND/OR/reserved/DIV-by-0 -> FIN,
//   MUL/DIV -> CALC with counter=WIDTH; Busy=1 from the cycle after Start.
//  CALC: one iteration per cycle; counter decrements; at counter==1 -> FIN.
//  FIN: write Saida/SaidaHi/flags, Done=1, Busy=0, -> IDLE (Start may be accepted same cycle as Done).
//  Latency Start->Done: 1 cycle for ADD/SUB/AND/OR/reserved/DIV-by-0; WIDTH+1 cycles for MUL/DIV.
//  ADD/SUB: modulo 2^WIDTH; Overflow = operand signs equal (B inverted for SUB) and result sign differs.
//  MUL: unsigned 2*WIDTH product {SaidaHi,Saida}; shift-add, multiplier LSB first.
//  DIV: unsigned restoring; quotient -> Saida, remainder -> SaidaHi.
//  DIV by 0: Saida = all ones, SaidaHi = EntradaA, DivZero=1, 1-cycle latency.
//  Reserved OP: Saida=0, SaidaHi=0, Zero=1, no other flags.
//  Zero computed on final Saida only; Overflow/DivZero cleared for every op that does not set them.
//  Operand inputs may change while Busy without effect (latched copies used).
//  Outputs hold previous values while Busy; Done is the only qualifier.
// STRUCTURE
//  Shared package alu_pkg: OP encodings (OP_ADD..OP_DIV), FSM state enum (IDLE, CALC, FIN).
//  One sub-module natural: alu_mul_div_iter (shared datapath: 2*WIDTH accumulator register,
//   shift, add/subtract-restore, counter); top holds FSM, single-cycle ops and flag logic.
// TESTING (WIDTH=32)
//  ADD A=2001 B=4001 -> Done 1 cycle after Start, Saida=6002, Zero=0, Overflow=0.
//  SUB A=0x7FFFFFFF B=0xFFFFFFFF -> Saida=0x80000000, Overflow=1; ADD A=0xFFFFFFFF B=1 -> Saida=0, Zero=1, Overflow=0.
//  MUL A=0xFFFFFFFF B=2 -> Done exactly 33 cycles after Start, Saida=0xFFFFFFFE, SaidaHi=1; Start pulses while Busy ignored.
//  DIV A=4001 B=2001 -> Saida=1, SaidaHi=2000, 33 cycles; DIV A=7 B=0 -> 1 cycle, Saida=0xFFFFFFFF, SaidaHi=7, DivZero=1.
//  rst asserted 10 cycles into MUL -> next cycle Busy=0, outputs 0, no Done; following AND 0xF0F0,0xFF00 -> Saida=0xF000.
//  Back-to-back: new Start in the Done cycle of an ADD accepted; second result correct one cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation encodings and FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_div_iter.sv
// Shared iterative datapath: shift-add multiply or restoring divide, one step per cycle.
module alu_mul_div_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               last
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               div_q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;

  // MUL keeps {partial product, multiplier}; DIV keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opnd};
    acc_next  = acc;
    if (div_q) begin
      if (!rem_diff[WIDTH])
        acc_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0])
        acc_next = {mul_sum, acc[WIDTH-1:1]};
      else
        acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  assign last = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      opnd  <= '0;
      div_q <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= is_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
      opnd  <= is_div ? b : a;
      div_q <= is_div;
      cnt   <= CNT_W'(WIDTH);
    end else if (step) begin
      acc <= acc_next;
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU with Start/Busy/Done handshake; results and flags held until the next op ends.
module alu_multiciclo
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] EntradaA,
  input  logic [WIDTH-1:0] EntradaB,
  output logic [WIDTH-1:0] Saida,
  output logic [WIDTH-1:0] SaidaHi,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivZero,
  output logic             Busy,
  output logic             Done
);

  state_e             state, state_next;
  logic               accept, long_op, b_zero;
  logic [WIDTH-1:0]   sum, diff, res_lo, res_hi;
  logic               res_ovf, res_dz;
  logic [2*WIDTH-1:0] acc_next;
  logic               last;

  assign b_zero  = (EntradaB == '0);
  assign accept  = Start && (state != CALC);
  assign long_op = (OP == OP_MUL) || ((OP == OP_DIV) && !b_zero);
  assign Busy    = (state == CALC);
  assign Done    = (state == FIN);

  alu_mul_div_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && long_op),
    .step     (state == CALC),
    .is_div   (OP == OP_DIV),
    .a        (EntradaA),
    .b        (EntradaB),
    .acc_next (acc_next),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FIN doubles as an idle slot so a new op can start in the Done cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, FIN: state_next = accept ? (long_op ? CALC : FIN) : IDLE;
      CALC:      if (last) state_next = FIN;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    sum     = EntradaA + EntradaB;
    diff    = EntradaA - EntradaB;
    res_lo  = '0;
    res_hi  = '0;
    res_ovf = 1'b0;
    res_dz  = 1'b0;
    case (OP)
      OP_ADD: begin
        res_lo  = sum;
        res_ovf = (EntradaA[WIDTH-1] == EntradaB[WIDTH-1]) && (sum[WIDTH-1] != EntradaA[WIDTH-1]);
      end
      OP_SUB: begin
        res_lo  = diff;
        res_ovf = (EntradaA[WIDTH-1] != EntradaB[WIDTH-1]) && (diff[WIDTH-1] != EntradaA[WIDTH-1]);
      end
      OP_AND: res_lo = EntradaA & EntradaB;
      OP_OR:  res_lo = EntradaA | EntradaB;
      OP_DIV: begin
        res_lo = '1;
        res_hi = EntradaA;
        res_dz = 1'b1;
      end
      default: ;
    endcase
  end

  // Long ops capture the final iteration directly so Done lands WIDTH+1 cycles after Start.
  always_ff @(posedge clk) begin
    if (rst) begin
      Saida    <= '0;
      SaidaHi  <= '0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
      DivZero  <= 1'b0;
    end else if ((state == CALC) && last) begin
      Saida    <= acc_next[WIDTH-1:0];
      SaidaHi  <= acc_next[2*WIDTH-1:WIDTH];
      Zero     <= (acc_next[WIDTH-1:0] == '0);
      Overflow <= 1'b0;
      DivZero  <= 1'b0;
    end else if (accept && !long_op) begin
      Saida    <= res_lo;
      SaidaHi  <= res_hi;
      Zero     <= (res_lo == '0);
      Overflow <= res_ovf;
      DivZero  <= res_dz;
    end
  end

endmodule
